i2s_codec_tx: RTL and testbench

- Codec-side I2S master transmitter. Generates BCLK and ADCLRCK and serializes stereo PCM on ADCDAT.
- Drives the audio-in pins of the reverb system (audio_BCLK, audio_ADCLRCK, audio_ADCDAT) during loopback and bench tests. The on-chip audio core then receives exactly what a WM8731 in master mode would send.
- Parallel stereo samples enter through a valid/ready port, are double-buffered, and are sent one frame per sample pair.

---
 rtl/i2s_codec_tx_if.sv | 24 ++
 rtl/i2s_codec_tx.sv | 125 ++++++++++++
 tb/tb_i2s_codec_tx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_codec_tx_if.sv
// Parallel stereo sample handshake into the codec-side I2S transmitter.
// The producer side is the master; the transmitter is the slave.
interface i2s_codec_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] sample_left;
    logic [DATA_WIDTH-1:0] sample_right;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_codec_tx.sv
// Codec-side I2S master transmitter: generates BCLK/LRCK and serializes
// double-buffered stereo PCM on DAT, MSB first, one BCLK after each LRCK edge.
module i2s_codec_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_HALF  = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_enable,
    i2s_codec_tx_if.slave s_smp,
    output logic          o_bclk,
    output logic          o_lrck,
    output logic          o_dat,
    output logic          o_frame_start,
    output logic          o_underrun
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DIVW       = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_HALF - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0]   SLOT_L   = BW'(SLOT_BITS);
    localparam logic [BW-1:0]   DATA_L   = BW'(DATA_WIDTH);

    logic [DIVW-1:0]       r_div;
    logic [BW-1:0]         r_bit;
    logic                  r_bclk;
    logic                  r_lrck;
    logic                  r_dat;
    logic                  r_frame_start;
    logic                  r_underrun;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_l;
    logic [DATA_WIDTH-1:0] r_hold_r;
    logic [DATA_WIDTH-1:0] r_sh_l;
    logic [DATA_WIDTH-1:0] r_sh_r;

    logic [BW-1:0] w_bit_nxt;
    logic [BW-1:0] w_slot;
    logic          w_fall;
    logic          w_load;
    logic          w_in_data;
    logic          w_xfer;

    assign w_bit_nxt = (r_bit == BIT_LAST) ? '0 : r_bit + BW'(1);
    assign w_slot    = (w_bit_nxt >= SLOT_L) ? w_bit_nxt - SLOT_L : w_bit_nxt;
    assign w_fall    = i_enable && (r_div == DIV_LAST) && r_bclk;
    assign w_load    = w_fall && (w_bit_nxt == '0);
    assign w_in_data = (w_slot != '0) && (w_slot <= DATA_L);
    assign w_xfer    = s_smp.sample_valid && !r_hold_full;

    assign s_smp.sample_ready = ~r_hold_full;
    assign o_bclk        = r_bclk;
    assign o_lrck        = r_lrck;
    assign o_dat         = r_dat;
    assign o_frame_start = r_frame_start;
    assign o_underrun    = r_underrun;

    // A load only empties a full holding register and a transfer only fills an
    // empty one, so the two never contend for r_hold_full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
        end else if (w_xfer) begin
            r_hold_full <= 1'b1;
            r_hold_l    <= s_smp.sample_left;
            r_hold_r    <= s_smp.sample_right;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div         <= '0;
            r_bit         <= BIT_LAST;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_dat         <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_sh_l        <= '0;
            r_sh_r        <= '0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            if (!i_enable) begin
                r_div  <= '0;
                r_bit  <= BIT_LAST;
                r_bclk <= 1'b0;
                r_lrck <= 1'b0;
                r_dat  <= 1'b0;
            end else if (r_div != DIV_LAST) begin
                r_div <= r_div + DIVW'(1);
            end else begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
                if (r_bclk) begin
                    // Fall event: everything the next rising edge samples changes here.
                    r_bit  <= w_bit_nxt;
                    r_lrck <= (w_bit_nxt >= SLOT_L);
                    r_dat  <= 1'b0;
                    if (w_load) begin
                        r_frame_start <= 1'b1;
                        r_underrun    <= ~r_hold_full;
                        r_sh_l        <= r_hold_full ? r_hold_l : '0;
                        r_sh_r        <= r_hold_full ? r_hold_r : '0;
                    end else if (w_in_data) begin
                        if (w_bit_nxt >= SLOT_L) begin
                            r_dat  <= r_sh_r[DATA_WIDTH-1];
                            r_sh_r <= r_sh_r << 1;
                        end else begin
                            r_dat  <= r_sh_l[DATA_WIDTH-1];
                            r_sh_l <= r_sh_l << 1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_codec_tx.sv
// Bench for i2s_codec_tx: per-cycle arithmetic reference model, table of
// directed frames, randomized streaming, and enable/reset corner sequences.
module tb_i2s_codec_tx;
    localparam int DW = 24;
    localparam int SB = 32;
    localparam int BH = 2;
    localparam int FB = 2 * SB;
    localparam int FRAME_CLK = FB * 2 * BH;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic en = 1'b0;
    logic en1 = 1'b0;
    logic bclk, lrck, dat, fs, ur;
    logic bclk1, lrck1, dat1, fs1, ur1;

    i2s_codec_tx_if #(.DATA_WIDTH(DW)) sif ();
    i2s_codec_tx_if #(.DATA_WIDTH(DW)) sif1 ();

    i2s_codec_tx #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .BCLK_HALF(BH)) u_dut (
        .clk(clk), .reset_n(reset_n), .i_enable(en), .s_smp(sif.slave),
        .o_bclk(bclk), .o_lrck(lrck), .o_dat(dat),
        .o_frame_start(fs), .o_underrun(ur)
    );

    i2s_codec_tx #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .BCLK_HALF(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .i_enable(en1), .s_smp(sif1.slave),
        .o_bclk(bclk1), .o_lrck(lrck1), .o_dat(dat1),
        .o_frame_start(fs1), .o_underrun(ur1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [SB-1:0] slot_word(input bit [DW-1:0] v);
        return SB'(v) << (SB - 1 - DW);
    endfunction

    // Reference model: outputs follow from the number of enabled clk edges.
    bit [2*DW-1:0] hq[$];
    bit [DW-1:0]   cl = '0, cr = '0;
    int            e = 0;
    int            k_now = -1;
    logic          en_s = 1'b0, val_s = 1'b0;
    logic [DW-1:0] l_s = '0, r_s = '0;
    bit [SB-1:0]   wl = '0, wr = '0, cap_l = '0, cap_r = '0;
    int            cap_n = 0, fs_n = 0, ur_n = 0, acc_n = 0;
    int            cyc = 0, fs_last = 0, fs_period = 0;
    bit            chk_on = 1'b0;

    always @(negedge clk) begin
        int t, m, k, s;
        bit load, was_empty, eb, el, ed;
        bit [DW-1:0] smp;
        cyc++;
        load = 1'b0;
        was_empty = (hq.size() == 0);
        if (!reset_n) begin
            hq.delete();
            e = 0;
            cl = '0;
            cr = '0;
            was_empty = 1'b1;
        end else begin
            if (en_s) e++;
            else e = 0;
            t = e / BH;
            load = en_s && (e % BH == 0) && (t > 0) && (t % 2 == 0) && (((t / 2) - 1) % FB == 0);
            if (load) begin
                if (!was_empty) {cl, cr} = hq.pop_front();
                else begin
                    cl = '0;
                    cr = '0;
                end
            end
            if (val_s && was_empty) hq.push_back({l_s, r_s});
        end
        t = e / BH;
        m = t / 2;
        eb = (t % 2 == 1);
        if (m == 0) begin
            k = -1; el = 1'b0; ed = 1'b0;
        end else begin
            k = (m - 1) % FB;
            el = (k >= SB);
            s = k % SB;
            smp = el ? cr : cl;
            ed = (s >= 1 && s <= DW) ? smp[DW-s] : 1'b0;
        end
        k_now = k;
        if (chk_on)
            check("outputs{bclk,lrck,dat,fs,ur,rdy}", {26'd0, bclk, lrck, dat, fs, ur, sif.sample_ready},
                  {26'd0, eb, el, ed, load, load && was_empty, hq.size() == 0});
        if (reset_n && en_s && (e % BH == 0) && eb && m >= 1) begin
            if (k < SB) wl[SB-1-k] = dat;
            else wr[FB-1-k] = dat;
            if (k == FB - 1) begin
                cap_l = wl;
                cap_r = wr;
                cap_n++;
            end
        end
        if (fs === 1'b1) begin
            fs_n++;
            fs_period = cyc - fs_last;
            fs_last = cyc;
        end
        if (ur === 1'b1) ur_n++;
        if (reset_n && sif.sample_valid && hq.size() == 0) acc_n++;
        en_s = en;
        val_s = sif.sample_valid;
        l_s = sif.sample_left;
        r_s = sif.sample_right;
    end

    int cyc1 = 0, fs1_n = 0, ur1_n = 0, fs1_last = 0, fs1_period = 0;
    always @(negedge clk) begin
        cyc1++;
        if (fs1 === 1'b1) begin
            fs1_n++;
            fs1_period = cyc1 - fs1_last;
            fs1_last = cyc1;
        end
        if (ur1 === 1'b1) ur1_n++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_cap();
        int n0;
        n0 = cap_n;
        for (int c = 0; c < 3 * FRAME_CLK && cap_n == n0; c++) tick();
        check("capture_timeout", 32'(cap_n != n0), 32'd1);
    endtask

    task automatic prime(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int a0;
        a0 = acc_n;
        sif.sample_left = l;
        sif.sample_right = r;
        sif.sample_valid = 1'b1;
        for (int c = 0; c < 20 && acc_n == a0; c++) tick();
        sif.sample_valid = 1'b0;
        check("prime_accept", 32'(acc_n - a0), 32'd1);
    endtask

    int last_acc = 0;
    logic [DW-1:0] held_l = '0, held_r = '0;

    task automatic stream(input int ncyc, input int stop_k);
        for (int c = 0; c < ncyc; c++) begin
            if (stop_k >= 0 && k_now == stop_k) break;
            tick();
            if (acc_n != last_acc) begin
                last_acc = acc_n;
                held_l = sif.sample_left;
                held_r = sif.sample_right;
                sif.sample_left = DW'($urandom);
                sif.sample_right = DW'($urandom);
            end
        end
    endtask

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [SB-1:0] exp_l;
        logic [SB-1:0] exp_r;
    } vec_t;
    vec_t vec[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, a0;
        vec[0] = '{24'hA5F00F, 24'h000001, 32'h52F80780, 32'h00000080};
        vec[1] = '{24'hFFFFFF, 24'h800000, 32'h7FFFFF80, 32'h40000000};
        vec[2] = '{24'h000000, 24'h7FFFFF, 32'h00000000, 32'h3FFFFF80};
        vec[3] = '{24'h123456, 24'hFEDCBA, 32'h091A2B00, 32'h7F6E5D00};
        sif.sample_valid = 1'b0;
        sif.sample_left = '0;
        sif.sample_right = '0;
        sif1.sample_valid = 1'b0;
        sif1.sample_left = '0;
        sif1.sample_right = '0;

        #1 reset_n = 1'b0;
        #2;
        check("reset_outputs", {27'd0, bclk, lrck, dat, fs, ur}, 32'd0);
        check("reset_ready", 32'(sif.sample_ready), 32'd1);
        tick(3);
        reset_n = 1'b1;
        chk_on = 1'b1;
        tick(100);
        check("idle_no_frames", 32'(fs_n), 32'd0);

        for (int i = 0; i < 4; i++) begin
            prime(vec[i].l, vec[i].r);
            check("ready_low_when_held", 32'(sif.sample_ready), 32'd0);
            en = 1'b1;
            wait_cap();
            check("left_slot_word", cap_l, vec[i].exp_l);
            check("right_slot_word", cap_r, vec[i].exp_r);
            if (i == 0) begin
                u0 = ur_n;
                wait_cap();
                check("underrun_left_zero", cap_l, 32'd0);
                check("underrun_right_zero", cap_r, 32'd0);
                check("underrun_pulse_count", 32'(ur_n - u0), 32'd1);
                check("frame_period", 32'(fs_period), 32'(FRAME_CLK));
            end
            en = 1'b0;
            tick(4);
        end

        last_acc = acc_n;
        sif.sample_left = DW'($urandom);
        sif.sample_right = DW'($urandom);
        sif.sample_valid = 1'b1;
        stream(20, -1);
        check("stream_prime", 32'(sif.sample_ready), 32'd0);
        en = 1'b1;
        u0 = ur_n;
        a0 = acc_n;
        stream(10 * FRAME_CLK, -1);
        check("stream_no_underrun", 32'(ur_n - u0), 32'd0);
        check("stream_one_accept_per_frame", 32'(acc_n - a0), 32'd10);
        check("stream_frame_period", 32'(fs_period), 32'(FRAME_CLK));

        stream(2 * FRAME_CLK, 40);
        check("reach_bit40", 32'(k_now), 32'd40);
        sif.sample_valid = 1'b0;
        en = 1'b0;
        tick();
        check("disable_forces_zero", {29'd0, bclk, lrck, dat}, 32'd0);
        tick(20);
        check("holding_retained", 32'(sif.sample_ready), 32'd0);
        en = 1'b1;
        wait_cap();
        check("restart_left_word", cap_l, slot_word(held_l));
        check("restart_right_word", cap_r, slot_word(held_r));

        for (int c = 0; c < 2 * FRAME_CLK && k_now != 45; c++) tick();
        check("reach_bit45", 32'(k_now), 32'd45);
        check("lrck_high_right_slot", 32'(lrck), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {26'd0, bclk, lrck, dat, fs, ur, sif.sample_ready}, 32'd1);
        en = 1'b0;
        tick(3);
        u0 = fs_n;
        reset_n = 1'b1;
        tick(100);
        check("post_reset_idle", 32'(fs_n - u0), 32'd0);

        en1 = 1'b1;
        for (int c = 0; c < 1000 && fs1_n < 3; c++) tick();
        check("bh1_frames_seen", 32'(fs1_n >= 3), 32'd1);
        check("bh1_frame_period", 32'(fs1_period), 32'd128);
        check("bh1_underrun_every_frame", 32'(ur1_n), 32'(fs1_n));
        en1 = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
